// File: rtl/dbg_hart_mailbox.sv
// Debug mailbox between a host debug module and a halted hart: halt/resume/command handshake FSM plus shared data registers.
// Hart bus: granted same cycle, response one cycle later; host side is always ready (writes dropped while a command is busy).
module dbg_hart_mailbox #(
  parameter int          DataCount = 2,
  parameter logic [11:0] DataAddr  = 12'h380
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        debug_req_o,
  input  logic        haltreq_i,
  input  logic        resumereq_i,
  input  logic        cmd_go_i,
  input  logic        err_clr_i,
  input  logic        host_we_i,
  input  logic [3:0]  host_idx_i,
  input  logic [31:0] host_wdata_i,
  output logic [31:0] host_rdata_o,
  output logic        halted_o,
  output logic        cmd_busy_o,
  output logic        cmd_err_o
);

  localparam logic [11:0] AddrHalted    = 12'h100;
  localparam logic [11:0] AddrGoing     = 12'h108;
  localparam logic [11:0] AddrResuming  = 12'h110;
  localparam logic [11:0] AddrException = 12'h118;
  localparam logic [11:0] AddrFlags     = 12'h300;

  typedef enum logic [2:0] {
    RUNNING,
    HALT_REQ,
    HALTED,
    CMD_GO,
    CMD_EXEC,
    RESUME
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] data_q [DataCount];
  logic [31:0] rd_val;

  logic        hart_wr;
  logic        wr_halted;
  logic        wr_going;
  logic        wr_resuming;
  logic        wr_exception;
  logic        err_set;
  logic [11:0] doff;
  logic [9:0]  didx;
  logic        data_hit;

  assign gnt_o        = req_i;
  assign hart_wr      = req_i & we_i;
  assign wr_halted    = hart_wr && (addr_i == AddrHalted);
  assign wr_going     = hart_wr && (addr_i == AddrGoing);
  assign wr_resuming  = hart_wr && (addr_i == AddrResuming);
  assign wr_exception = hart_wr && (addr_i == AddrException);
  assign err_set      = (state == CMD_EXEC) && wr_exception;

  // Addresses below DataAddr wrap to a huge offset and fall outside the window.
  assign doff     = addr_i - DataAddr;
  assign didx     = doff[11:2];
  assign data_hit = (doff[1:0] == 2'b00) && (int'(didx) < DataCount);

  always_comb begin
    state_nxt = state;
    case (state)
      RUNNING:  if (haltreq_i) state_nxt = HALT_REQ;
      HALT_REQ: if (wr_halted) state_nxt = HALTED;
      HALTED: begin
        if (cmd_go_i && !cmd_err_o) state_nxt = CMD_GO;
        else if (resumereq_i)       state_nxt = RESUME;
      end
      CMD_GO:   if (wr_going) state_nxt = CMD_EXEC;
      CMD_EXEC: if (wr_halted || wr_exception) state_nxt = HALTED;
      RESUME:   if (wr_resuming) state_nxt = RUNNING;
      default:  state_nxt = RUNNING;
    endcase
  end

  always_comb begin
    rd_val = 32'h0;
    if (addr_i == AddrFlags) begin
      rd_val = {30'h0, state == RESUME, state == CMD_GO};
    end
    for (int i = 0; i < DataCount; i++) begin
      if (data_hit && (didx == 10'(i))) rd_val = data_q[i];
    end
  end

  always_comb begin
    host_rdata_o = 32'h0;
    for (int i = 0; i < DataCount; i++) begin
      if (host_idx_i == 4'(i)) host_rdata_o = data_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUNNING;
      debug_req_o <= 1'b0;
      halted_o    <= 1'b0;
      cmd_busy_o  <= 1'b0;
      cmd_err_o   <= 1'b0;
      rvalid_o    <= 1'b0;
      rdata_o     <= 32'h0;
      for (int i = 0; i < DataCount; i++) data_q[i] <= 32'h0;
    end else begin
      state       <= state_nxt;
      debug_req_o <= (state_nxt == HALT_REQ);
      halted_o    <= (state_nxt == HALTED) || (state_nxt == CMD_GO) || (state_nxt == CMD_EXEC);
      cmd_busy_o  <= (state_nxt == CMD_GO) || (state_nxt == CMD_EXEC);
      if (err_set)        cmd_err_o <= 1'b1;
      else if (err_clr_i) cmd_err_o <= 1'b0;
      rvalid_o <= req_i;
      rdata_o  <= (req_i && !we_i) ? rd_val : 32'h0;
      // Hart write takes priority over a host write to the same register.
      for (int i = 0; i < DataCount; i++) begin
        if (hart_wr && data_hit && (didx == 10'(i)))
          data_q[i] <= wdata_i;
        else if (host_we_i && !cmd_busy_o && (host_idx_i == 4'(i)))
          data_q[i] <= host_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dbg_hart_mailbox.sv
// Bench for dbg_hart_mailbox: directed handshake scenarios then random traffic against a behavioural model.
module tb_dbg_hart_mailbox;
  localparam int DC = 2;
  localparam int DA = 'h380;

  localparam int P_RUN  = 0;
  localparam int P_HREQ = 1;
  localparam int P_HLT  = 2;
  localparam int P_GO   = 3;
  localparam int P_EXEC = 4;
  localparam int P_RES  = 5;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, debug_req_o, halted_o, cmd_busy_o, cmd_err_o;
  logic [31:0] rdata_o, host_rdata_o;
  logic        haltreq_i = 1'b0, resumereq_i = 1'b0, cmd_go_i = 1'b0, err_clr_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [3:0]  host_idx_i = '0;
  logic [31:0] host_wdata_i = '0;

  always #5 clk = ~clk;

  dbg_hart_mailbox #(.DataCount(DC), .DataAddr(12'h380)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .debug_req_o(debug_req_o), .haltreq_i(haltreq_i), .resumereq_i(resumereq_i),
    .cmd_go_i(cmd_go_i), .err_clr_i(err_clr_i), .host_we_i(host_we_i),
    .host_idx_i(host_idx_i), .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o),
    .halted_o(halted_o), .cmd_busy_o(cmd_busy_o), .cmd_err_o(cmd_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Behavioural model: handshake phase, sticky error, data registers, pending response.
  int          m_ph = P_RUN;
  logic        m_err = 1'b0;
  logic [31:0] m_data [DC];
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int ai = int'(a);
    if (ai == 'h300) return {30'h0, m_ph == P_RES, m_ph == P_GO};
    if (ai >= DA && ai < DA + 4*DC && (ai % 4) == 0) return m_data[(ai - DA) / 4];
    return 32'h0;
  endfunction

  task automatic cycle();
    int          ph_n = m_ph;
    logic        err_n = m_err;
    logic [31:0] d_n [DC];
    logic        rv_n;
    logic [31:0] rd_n;
    int          ai = int'(addr_i);
    bit          hw = req_i && we_i;
    bit          busy = (m_ph == P_GO) || (m_ph == P_EXEC);
    d_n = m_data;
    if (rst_i) begin
      ph_n = P_RUN; err_n = 1'b0; rv_n = 1'b0; rd_n = 32'h0;
      for (int i = 0; i < DC; i++) d_n[i] = 32'h0;
    end else begin
      rv_n = req_i;
      rd_n = (req_i && !we_i) ? m_read(addr_i) : 32'h0;
      if (host_we_i && !busy && int'(host_idx_i) < DC) d_n[host_idx_i] = host_wdata_i;
      if (hw && ai >= DA && ai < DA + 4*DC && (ai % 4) == 0) d_n[(ai - DA) / 4] = wdata_i;
      if (m_ph == P_EXEC && hw && ai == 'h118) err_n = 1'b1;
      else if (err_clr_i) err_n = 1'b0;
      case (m_ph)
        P_RUN:  if (haltreq_i) ph_n = P_HREQ;
        P_HREQ: if (hw && ai == 'h100) ph_n = P_HLT;
        P_HLT: begin
          if (cmd_go_i && !m_err) ph_n = P_GO;
          else if (resumereq_i)   ph_n = P_RES;
        end
        P_GO:   if (hw && ai == 'h108) ph_n = P_EXEC;
        P_EXEC: if (hw && (ai == 'h100 || ai == 'h118)) ph_n = P_HLT;
        P_RES:  if (hw && ai == 'h110) ph_n = P_RUN;
        default: ph_n = P_RUN;
      endcase
    end
    @(posedge clk);
    #1;
    m_ph = ph_n; m_err = err_n; m_data = d_n; m_rvalid = rv_n; m_rdata = rd_n;
    check_eq("gnt", 32'(gnt_o), 32'(req_i));
    check_eq("rvalid", 32'(rvalid_o), 32'(m_rvalid));
    check_eq("rdata", rdata_o, m_rdata);
    check_eq("debug_req", 32'(debug_req_o), 32'(m_ph == P_HREQ));
    check_eq("halted", 32'(halted_o), 32'(m_ph == P_HLT || m_ph == P_GO || m_ph == P_EXEC));
    check_eq("cmd_busy", 32'(cmd_busy_o), 32'(m_ph == P_GO || m_ph == P_EXEC));
    check_eq("cmd_err", 32'(cmd_err_o), 32'(m_err));
    check_eq("host_rdata", host_rdata_o, (int'(host_idx_i) < DC) ? m_data[host_idx_i] : 32'h0);
  endtask

  task automatic hart(input logic w, input logic [11:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    cycle();
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic pulse_go();
    cmd_go_i = 1'b1; cycle(); cmd_go_i = 1'b0;
  endtask

  logic [11:0] addr_tab [10];

  initial begin
    for (int i = 0; i < DC; i++) m_data[i] = 32'h0;
    addr_tab = '{12'h100, 12'h108, 12'h110, 12'h118, 12'h300,
                 12'h380, 12'h384, 12'h388, 12'h37C, 12'h000};

    rst_i = 1'b1; cycle(); cycle(); rst_i = 1'b0;
    check_eq("reset_halted", 32'(halted_o), 32'h0);

    // Halt handshake, with haltreq dropped before the hart acknowledges.
    haltreq_i = 1'b1; cycle(); haltreq_i = 1'b0;
    check_eq("halt_dbg_req", 32'(debug_req_o), 32'h1);
    cycle();
    hart(1'b1, 12'h100, 32'h0);
    check_eq("halt_dbg_clr", 32'(debug_req_o), 32'h0);
    check_eq("halt_halted", 32'(halted_o), 32'h1);

    // Abstract command.
    host_we_i = 1'b1; host_idx_i = 4'd0; host_wdata_i = 32'hCAFE0001; cycle(); host_we_i = 1'b0;
    pulse_go();
    hart(1'b0, 12'h300, 32'h0);
    check_eq("cmd_flags_go", rdata_o, 32'h1);
    hart(1'b0, 12'h380, 32'h0);
    check_eq("cmd_data0", rdata_o, 32'hCAFE0001);
    hart(1'b1, 12'h108, 32'h0);
    hart(1'b1, 12'h100, 32'h0);
    check_eq("cmd_busy_done", 32'(cmd_busy_o), 32'h0);
    check_eq("cmd_no_err", 32'(cmd_err_o), 32'h0);

    // Exception path; go is ignored while the error is set.
    pulse_go();
    hart(1'b1, 12'h108, 32'h0);
    hart(1'b1, 12'h118, 32'h0);
    check_eq("exc_err", 32'(cmd_err_o), 32'h1);
    check_eq("exc_halted", 32'(halted_o), 32'h1);
    pulse_go();
    check_eq("exc_go_ignored", 32'(cmd_busy_o), 32'h0);
    err_clr_i = 1'b1; cycle(); err_clr_i = 1'b0;
    check_eq("exc_clr", 32'(cmd_err_o), 32'h0);

    // Host/hart conflict on data1 during CMD_EXEC.
    pulse_go();
    hart(1'b1, 12'h108, 32'h0);
    host_we_i = 1'b1; host_idx_i = 4'd1; host_wdata_i = 32'h1111;
    hart(1'b1, 12'h384, 32'h2222);
    host_we_i = 1'b0;
    check_eq("conflict_data1", host_rdata_o, 32'h2222);
    hart(1'b1, 12'h100, 32'h0);
    cmd_go_i = 1'b1; resumereq_i = 1'b1; cycle(); cmd_go_i = 1'b0; resumereq_i = 1'b0;
    hart(1'b0, 12'h300, 32'h0);
    check_eq("go_beats_resume", rdata_o, 32'h1);
    hart(1'b1, 12'h108, 32'h0);
    hart(1'b1, 12'h100, 32'h0);

    // Resume.
    resumereq_i = 1'b1; cycle(); resumereq_i = 1'b0;
    hart(1'b0, 12'h300, 32'h0);
    check_eq("resume_flags", rdata_o, 32'h2);
    hart(1'b1, 12'h110, 32'h0);
    check_eq("resume_halted", 32'(halted_o), 32'h0);

    // Reset during CMD_GO with a read granted in the reset cycle.
    haltreq_i = 1'b1; cycle(); haltreq_i = 1'b0;
    hart(1'b1, 12'h100, 32'h0);
    pulse_go();
    rst_i = 1'b1; hart(1'b0, 12'h380, 32'h0); rst_i = 1'b0;
    check_eq("rst_rvalid", 32'(rvalid_o), 32'h0);
    check_eq("rst_busy", 32'(cmd_busy_o), 32'h0);
    check_eq("rst_halted", 32'(halted_o), 32'h0);
    hart(1'b0, 12'h384, 32'h0);
    check_eq("rst_data1", rdata_o, 32'h0);
    check_eq("rst_read_rvalid", 32'(rvalid_o), 32'h1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      req_i        = ($urandom_range(0, 1) == 1);
      we_i         = ($urandom_range(0, 1) == 1);
      addr_i       = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 1023) * 4)
                                                 : addr_tab[$urandom_range(0, 9)];
      wdata_i      = $urandom;
      haltreq_i    = ($urandom_range(0, 3) == 0);
      resumereq_i  = ($urandom_range(0, 7) == 0);
      cmd_go_i     = ($urandom_range(0, 5) == 0);
      err_clr_i    = ($urandom_range(0, 15) == 0);
      host_we_i    = ($urandom_range(0, 1) == 1);
      host_idx_i   = 4'($urandom_range(0, 15));
      host_wdata_i = $urandom;
      rst_i        = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_hart_mailbox.md
DBG_HART_MAILBOX -- requirements
Module: dbg_hart_mailbox

Interface
REQ-001 SHALL have parameter DataCount, default 2, meaning the number of 32-bit data registers (1..12).
REQ-002 SHALL have parameter DataAddr, default 12'h380, meaning the byte offset of data0 in the hart-visible window.
REQ-003 SHALL have these ports (name direction width meaning):
 clk_i input 1 sole clock;
 rst_i input 1 synchronous active-high reset;
 req_i input 1 hart bus request;
 we_i input 1 hart write enable;
 addr_i input 12 hart byte address, word-aligned;
 wdata_i input 32 hart write data;
 gnt_o output 1 grant;
 rvalid_o output 1 response valid;
 rdata_o output 32 read data;
 debug_req_o output 1 halt request to hart;
 haltreq_i input 1 host halt request, level;
 resumereq_i input 1 host resume request, pulse;
 cmd_go_i input 1 host abstract-command start, pulse;
 err_clr_i input 1 clears cmd_err_o;
 host_we_i input 1 host data-register write;
 host_idx_i input 4 host data-register index;
 host_wdata_i input 32 host write data;
 host_rdata_o output 32 data[host_idx_i], combinational;
 halted_o output 1 hart halted;
 cmd_busy_o output 1 command in flight;
 cmd_err_o output 1 sticky command exception.

Function
REQ-004 SHALL grant every hart request in the cycle it is presented (gnt_o = req_i).
REQ-005 SHALL assert rvalid_o exactly one cycle after each granted request, with rdata_o valid in that cycle and 0 on writes.
REQ-006 SHALL decode the hart window as: 0x100 HALTED (W), 0x108 GOING (W), 0x110 RESUMING (W), 0x118 EXCEPTION (W), 0x300 FLAGS (R: bit0 go, bit1 resume, others 0), and DataAddr+4*i data[i] (R/W).
REQ-007 SHALL read unmapped addresses as 0 and ignore writes to them without error.
REQ-008 SHALL implement the FSM states RUNNING, HALT_REQ, HALTED, CMD_GO, CMD_EXEC, RESUME.
REQ-009 In RUNNING, haltreq_i=1 SHALL move the FSM to HALT_REQ on the next cycle.
REQ-010 debug_req_o SHALL be 1 exactly while the FSM is in HALT_REQ.
REQ-011 In HALT_REQ, a hart write to HALTED SHALL move the FSM to HALTED; deasserting haltreq_i SHALL NOT abort the request.
REQ-012 In HALTED, cmd_go_i SHALL move the FSM to CMD_GO. Otherwise resumereq_i SHALL move it to RESUME. If both arrive in the same cycle, cmd_go_i wins and resumereq_i is dropped.
REQ-013 FLAGS.go SHALL be 1 only in CMD_GO.
REQ-014 In CMD_GO, a hart write to GOING SHALL move the FSM to CMD_EXEC.
REQ-015 In CMD_EXEC, a hart write to HALTED SHALL return the FSM to HALTED; a write to EXCEPTION SHALL set cmd_err_o and return the FSM to HALTED.
REQ-016 FLAGS.resume SHALL be 1 only in RESUME.
REQ-017 In RESUME, a hart write to RESUMING SHALL move the FSM to RUNNING.
REQ-018 halted_o SHALL be 1 in HALTED, CMD_GO and CMD_EXEC; cmd_busy_o SHALL be 1 in CMD_GO and CMD_EXEC.
REQ-019 cmd_go_i SHALL be ignored outside HALTED, and resumereq_i SHALL be ignored outside HALTED.
REQ-020 A state-control write that does not match the current state SHALL be ignored and SHALL NOT change any state.
REQ-021 cmd_err_o SHALL stay set until err_clr_i; if err_clr_i and an EXCEPTION write arrive in the same cycle, the flag ends set.
REQ-022 While cmd_err_o=1, cmd_go_i SHALL be ignored.
REQ-023 host_we_i SHALL update data[host_idx_i] on the next edge only when cmd_busy_o=0.
REQ-024 If a host write and a hart write target the same data register in the same cycle, the hart write wins.
REQ-025 A host_idx_i of DataCount or more SHALL make host writes no-ops and host_rdata_o read as 0.
REQ-026 Hart reads of data[i] in the same cycle as a hart write SHALL return the pre-write value.

Reset
REQ-027 Sampling rst_i=1 on a clk_i edge SHALL put the FSM in RUNNING and clear all data registers, rvalid_o, rdata_o, debug_req_o, halted_o, cmd_busy_o and cmd_err_o to 0.
REQ-028 A reset mid-operation SHALL discard any pending handshake, and the response for a request granted in the reset cycle SHALL be suppressed.

Verification
REQ-029 Halt: haltreq_i=1 -> debug_req_o=1 next cycle; hart writes 0x100 -> debug_req_o=0 and halted_o=1 next cycle.
REQ-030 Command: halted, host writes data0=32'hCAFE0001, then cmd_go_i -> hart reads 0x300=1 and 0x380=32'hCAFE0001; hart writes 0x108 then 0x100 -> cmd_busy_o falls to 0, cmd_err_o=0.
REQ-031 Exception: hart writes 0x118 in CMD_EXEC -> cmd_err_o=1 and halted_o=1; a following cmd_go_i is ignored; err_clr_i -> cmd_err_o=0.
REQ-032 Conflict: in CMD_EXEC, host writes data1=32'h1111 while the hart writes data1=32'h2222 -> data1=32'h2222. Simultaneous cmd_go_i and resumereq_i in HALTED -> FLAGS=1.
REQ-033 Resume and reset: resumereq_i -> FLAGS=2; hart writes 0x110 -> halted_o=0, FSM in RUNNING. Asserting rst_i during CMD_GO -> all outputs 0 next cycle; a read of 0x384 then returns 0.
